fifo_burst_framer: RTL

//  Downstream consumer of sync_fifo: pops words from the FIFO read port and emits them as fixed-length packets
//  on a valid/ready stream with o_tlast marking each packet's final word. Packets left incomplete when the FIFO

---
 rtl/fifo_burst_framer_pkg.sv | 21 ++
 rtl/skid_buf2.sv | 43 ++++
 rtl/fifo_burst_framer.sv | 109 ++++++++++
 3 files changed

// File: rtl/fifo_burst_framer_pkg.sv
// Shared types and helpers for the FIFO burst framer: FSM state encoding and a width helper.
package fifo_burst_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_PAD   = 2'd2
  } state_t;

  // Bits needed to index 0..value-1, never less than 1.
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry register buffer; head is the oldest word, simultaneous push/pop keeps the count.
module skid_buf2 #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] entry0;
  logic [DATA_WIDTH-1:0] entry1;
  logic [1:0]            cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      entry0 <= '0;
      entry1 <= '0;
      cnt    <= 2'd0;
    end else if (push && pop) begin
      if (cnt == 2'd2) begin
        entry0 <= entry1;
        entry1 <= din;
      end else begin
        entry0 <= din;
      end
    end else if (push) begin
      if (cnt == 2'd0) entry0 <= din;
      else             entry1 <= din;
      cnt <= cnt + 2'd1;
    end else if (pop) begin
      entry0 <= entry1;
      cnt    <= cnt - 2'd1;
    end
  end

  assign count = cnt;
  assign head  = entry0;

endmodule

// File: rtl/fifo_burst_framer.sv
// Pops words from a 1-cycle-latency FIFO and frames them into fixed-length packets on a valid/ready
// stream, padding a stalled packet with PAD_VALUE words after a timeout.
module fifo_burst_framer
  import fifo_burst_framer_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH  = 16,
  parameter int unsigned          BURST_LEN   = 4,
  parameter int unsigned          TIMEOUT_CYC = 8,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = DATA_WIDTH'(16'hDEAD)
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_rdata,
  output logic                  o_fifo_rden,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic                  o_tlast,
  output logic                  o_pad,
  output logic [15:0]           o_pkt_cnt,
  output logic                  o_busy
);

  localparam int unsigned CW = clog2_min1(BURST_LEN);
  localparam int unsigned TW = clog2_min1(TIMEOUT_CYC + 1);

  state_t                state, state_n;
  logic [CW-1:0]         word_cnt, word_cnt_n;
  logic [TW-1:0]         tcnt, tcnt_n;
  logic [15:0]           pkt_cnt, pkt_cnt_n;
  logic                  inflight;
  logic [1:0]            buf_count;
  logic [DATA_WIDTH-1:0] buf_head;
  logic                  xfer;
  logic                  pop;
  logic                  is_last;
  logic                  starved;

  skid_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk   (i_sys_clk),
    .rst   (i_sys_rst),
    .push  (inflight),
    .pop   (pop),
    .din   (i_fifo_rdata),
    .count (buf_count),
    .head  (buf_head)
  );

  // Credit: never have more words buffered or returning than the buffer can hold.
  assign o_fifo_rden = !i_fifo_empty && (state != ST_PAD) &&
                       ((3'(buf_count) + 3'(inflight)) < 3'd2);

  assign o_tvalid  = (state == ST_PAD) || (buf_count != 2'd0);
  assign o_tdata   = (state == ST_PAD) ? PAD_VALUE : buf_head;
  assign is_last   = (word_cnt == CW'(BURST_LEN - 1));
  assign o_tlast   = is_last;
  assign o_pad     = (state == ST_PAD);
  assign o_busy    = (state != ST_IDLE);
  assign o_pkt_cnt = pkt_cnt;

  assign xfer    = o_tvalid && i_tready;
  assign pop     = xfer && (state != ST_PAD);
  assign starved = (buf_count == 2'd0) && !inflight && i_fifo_empty;

  // Next-state: packet progress, timeout tracking and packet count.
  always_comb begin
    state_n    = state;
    word_cnt_n = word_cnt;
    tcnt_n     = '0;
    pkt_cnt_n  = pkt_cnt;

    if (xfer) begin
      if (is_last) begin
        word_cnt_n = '0;
        pkt_cnt_n  = pkt_cnt + 16'd1;
        state_n    = ST_IDLE;
      end else begin
        word_cnt_n = word_cnt + CW'(1);
        if (state == ST_IDLE) state_n = ST_BURST;
      end
    end

    if ((state == ST_BURST) && starved) begin
      if ((TIMEOUT_CYC != 0) && ((tcnt + TW'(1)) == TW'(TIMEOUT_CYC))) begin
        state_n = ST_PAD;
      end else begin
        tcnt_n = tcnt + TW'(1);
      end
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
      tcnt     <= '0;
      pkt_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_n;
      word_cnt <= word_cnt_n;
      tcnt     <= tcnt_n;
      pkt_cnt  <= pkt_cnt_n;
      inflight <= o_fifo_rden;
    end
  end

endmodule
